// File: rtl/intr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | intr_pkg : shared types and constants for the interrupt dispatcher       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUAL  = 2'd1,
    ST_PEND  = 2'd2,
    ST_INSRV = 2'd3
  } state_t;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_A    = 2'b01;
  localparam logic [1:0] BUS_B    = 2'b10;
  localparam logic [1:0] BUS_C    = 2'b11;

  localparam int         VEC_W    = 6;
  localparam logic [3:0] CHAN_MAX = 4'd8;

endpackage
`default_nettype wire

// File: rtl/intr_qualify.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | intr_qualify : winner selection, legality check and stability counter    |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module intr_qualify
  import intr_pkg::*;
#(
  parameter int unsigned QUAL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pa,
  input  logic             pb,
  input  logic             pc,
  input  logic [3:0]       chan,
  input  logic [2:0]       bus_mask,
  output logic             sample_vld,
  output logic             qual_hit,
  output logic [VEC_W-1:0] sample_vec,
  output logic             illegal
);

  localparam logic [3:0] c_qual_last = 4'(QUAL_CYCLES - 1);

  logic             w_a, w_b, w_c, w_same;
  logic [1:0]       w_bus;
  logic [3:0]       r_count;
  logic [VEC_W-1:0] r_cand;

  assign w_a = pa & ~bus_mask[0];
  assign w_b = pb & ~bus_mask[1];
  assign w_c = pc & ~bus_mask[2];

  assign w_bus = w_a ? BUS_A : (w_b ? BUS_B : (w_c ? BUS_C : BUS_NONE));

  // An out-of-range channel poisons the whole sample, not just its bus.
  assign illegal    = (w_bus != BUS_NONE) && (chan > CHAN_MAX);
  assign sample_vld = (w_bus != BUS_NONE) && !illegal;
  assign sample_vec = sample_vld ? {w_bus, chan} : '0;

  assign w_same   = (r_count != 4'd0) && (sample_vec == r_cand);
  assign qual_hit = en && sample_vld &&
                    (w_same ? (r_count == c_qual_last) : (c_qual_last == 4'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 4'd0;
      r_cand  <= '0;
    end else if (!en || !sample_vld || qual_hit) begin
      r_count <= 4'd0;
    end else if (w_same) begin
      r_count <= r_count + 4'd1;
    end else begin
      r_cand  <= sample_vec;
      r_count <= 4'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/intr_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | intr_dispatch : qualified interrupt latch with CPU req/ack/eoi handshake |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module intr_dispatch
  import intr_pkg::*;
#(
  parameter int unsigned QUAL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pa,
  input  logic             pb,
  input  logic             pc,
  input  logic [3:0]       chan,
  input  logic [2:0]       bus_mask,
  input  logic             irq_ack,
  input  logic             eoi,
  input  logic             err_clr,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  output logic             in_service,
  output logic             err
);

  state_t           r_state, w_state_nxt;
  logic             w_en, w_sample_vld, w_qual_hit, w_illegal;
  logic [VEC_W-1:0] w_sample_vec, r_vec;
  logic             r_err;

  // Sampling is frozen while a vector is pending or in service.
  assign w_en = (r_state == ST_IDLE) || (r_state == ST_QUAL);

  intr_qualify #(
    .QUAL_CYCLES(QUAL_CYCLES)
  ) u_qualify (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_en),
    .pa        (pa),
    .pb        (pb),
    .pc        (pc),
    .chan      (chan),
    .bus_mask  (bus_mask),
    .sample_vld(w_sample_vld),
    .qual_hit  (w_qual_hit),
    .sample_vec(w_sample_vec),
    .illegal   (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_sample_vld) w_state_nxt = w_qual_hit ? ST_PEND : ST_QUAL;
      ST_QUAL: begin
        if (w_qual_hit)         w_state_nxt = ST_PEND;
        else if (!w_sample_vld) w_state_nxt = ST_IDLE;
      end
      ST_PEND:  if (irq_ack) w_state_nxt = ST_INSRV;
      ST_INSRV: if (eoi)     w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_qual_hit)                         r_vec <= w_sample_vec;
      else if ((r_state == ST_INSRV) && eoi)  r_vec <= '0;
      if (w_illegal)    r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  assign irq_req    = (r_state == ST_PEND);
  assign in_service = (r_state == ST_INSRV);
  assign irq_vec    = r_vec;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_intr_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_intr_dispatch : directed scoreboard bench for intr_dispatch           |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_intr_dispatch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pa, pb, pc;
  logic [3:0] chan;
  logic [2:0] bus_mask;
  logic       irq_ack, eoi, err_clr;
  logic       irq_req, in_service, err;
  logic [5:0] irq_vec;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [5:0] exp_q[$];

  intr_dispatch #(.QUAL_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pa        (pa),
    .pb        (pb),
    .pc        (pc),
    .chan      (chan),
    .bus_mask  (bus_mask),
    .irq_ack   (irq_ack),
    .eoi       (eoi),
    .err_clr   (err_clr),
    .irq_req   (irq_req),
    .irq_vec   (irq_vec),
    .in_service(in_service),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic a, input logic b, input logic c, input logic [3:0] ch);
    pa = a; pb = b; pc = c; chan = ch;
  endtask

  // Pops the next expected vector and waits at most `budget` edges for irq_req.
  task automatic expect_dispatch(input string tag, input int budget);
    logic [5:0] e;
    int         k;
    e = exp_q.pop_front();
    k = 0;
    while (irq_req !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    chk({tag, "_req"}, 32'(irq_req), 32'd1);
    chk({tag, "_vec"}, 32'(irq_vec), 32'(e));
  endtask

  task automatic ack_and_eoi(input string tag, input logic [5:0] vec);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk({tag, "_ack_req"}, 32'(irq_req), 32'd0);
    chk({tag, "_ack_insrv"}, 32'(in_service), 32'd1);
    chk({tag, "_ack_vec"}, 32'(irq_vec), 32'(vec));
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    eoi = 1'b1; tick(1); eoi = 1'b0;
    chk({tag, "_eoi_insrv"}, 32'(in_service), 32'd0);
    chk({tag, "_eoi_vec"}, 32'(irq_vec), 32'd0);
    chk({tag, "_eoi_req"}, 32'(irq_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; drive(1'b0, 1'b0, 1'b0, 4'd0);
    bus_mask = 3'b000; irq_ack = 1'b0; eoi = 1'b0; err_clr = 1'b0;
    tick(2);
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_vec", 32'(irq_vec), 32'd0);
    chk("rst_insrv", 32'(in_service), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Basic dispatch: bus B channel 5, two qualifying edges.
    drive(1'b0, 1'b1, 1'b0, 4'd5);
    exp_q.push_back(6'b10_0101);
    tick(1);
    chk("b5_first_edge_req", 32'(irq_req), 32'd0);
    expect_dispatch("b5", 1);
    ack_and_eoi("b5", 6'b10_0101);

    // Candidate restart: A3 for one edge, then C7 held.
    drive(1'b1, 1'b0, 1'b0, 4'd3);
    tick(1);
    drive(1'b0, 1'b0, 1'b1, 4'd7);
    exp_q.push_back(6'b11_0111);
    tick(1);
    chk("restart_req", 32'(irq_req), 32'd0);
    expect_dispatch("c7", 1);

    // Vector frozen in PEND despite a higher-priority request appearing.
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    tick(2);
    chk("pend_hold_req", 32'(irq_req), 32'd1);
    chk("pend_hold_vec", 32'(irq_vec), 32'(6'b11_0111));
    ack_and_eoi("c7", 6'b11_0111);

    // irq_ack in IDLE is ignored.
    irq_ack = 1'b1; tick(2); irq_ack = 1'b0;
    chk("idle_ack_req", 32'(irq_req), 32'd0);
    chk("idle_ack_insrv", 32'(in_service), 32'd0);

    // Bus A masked: B wins.
    bus_mask = 3'b001;
    drive(1'b1, 1'b1, 1'b0, 4'd4);
    exp_q.push_back(6'b10_0100);
    expect_dispatch("mask_b4", 2);
    ack_and_eoi("mask_b4", 6'b10_0100);
    bus_mask = 3'b000;

    // Illegal channel: no dispatch, sticky err, set beats clear.
    drive(1'b0, 1'b0, 1'b1, 4'd12);
    tick(1);
    chk("illegal_err", 32'(err), 32'd1);
    tick(2);
    chk("illegal_noreq", 32'(irq_req), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    tick(1);
    chk("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd12);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("err_set_wins", 32'(err), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("err_clr2", 32'(err), 32'd0);

    // Asynchronous reset while in service, then redispatch of the held request.
    drive(1'b0, 1'b1, 1'b0, 4'd5);
    exp_q.push_back(6'b10_0101);
    expect_dispatch("pre_rst", 2);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("pre_rst_insrv", 32'(in_service), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(irq_req), 32'd0);
    chk("async_rst_insrv", 32'(in_service), 32'd0);
    chk("async_rst_vec", 32'(irq_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(6'b10_0101);
    tick(1);
    chk("post_rst_first_edge", 32'(irq_req), 32'd0);
    expect_dispatch("post_rst", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
